sifive_reset_gate: RTL and testbench
====================================

# sifive_reset_gate

- Power-on reset gate for the VCU118 shell; sits directly upstream of the board reset sequencer and produces the active-high asynchronous `areset` that the sequencer consumes.
- Runs on the free-running board reference clock.
- Resets the MMCMs and waits for every MMCM `locked` to be stable before releasing `areset`.
- Re-asserts `areset` on a debounced push-button press, a software reset request, or loss of lock.

## Interface
Parameters:
- `N_LOCK`, 4: number of MMCM `locked` inputs.
- `MMCM_RST_CYCLES`, 64: `mmcm_reset` pulse length in cycles (≥2).
- `STABLE_CYCLES`, 4096: cycles with all locks held high before `areset` drops (≥1).
- `DEBOUNCE_CYCLES`, 65536: consecutive synced button-high cycles that count as one press (≥1).
- `LOCK_TIMEOUT`, 1048576: cycles to wait for lock before retrying (used only with the macro).

Ports:
- `clock` in 1: free-running board reference clock.
- `aresetn` in 1: asynchronous active-low reset (power-on / GSR); one clock; reset is asynchronous and active-low.
- `locked` in N_LOCK: MMCM lock flags, asynchronous.
- `button` in 1: push-button, active-high, asynchronous, bouncy.
- `sw_reset_req` in 1: single-cycle synchronous request from the debug module.
- `mmcm_reset` out 1: registered, active-high reset to all MMCMs.
- `areset` out 1: registered, active-high reset to the downstream sequencer.
- `state` out 2: current FSM state, for status/ILA.

## Operation
- Inputs `locked[i]` and `button` each pass through a 2-flop synchronizer. `all_locked` is the AND of the synced locks.
- FSM states:
  - HOLD_MMCM (0): `mmcm_reset`=1, `areset`=1. Counts `MMCM_RST_CYCLES` edges, then goes to WAIT_LOCK.
  - WAIT_LOCK (1): `mmcm_reset`=0, `areset`=1. Goes to STABLE on the first edge with `all_locked`=1, with the counter cleared.
  - STABLE (2): `areset`=1. Counts edges while `all_locked`=1. At count `STABLE_CYCLES`, goes to RUN.
  - RUN (3): `areset`=0, `mmcm_reset`=0.
- Priority, evaluated each edge:
  1. `all_locked`=0 in STABLE or RUN → HOLD_MMCM.
  2. A press event or `sw_reset_req` in STABLE or RUN → STABLE, counter cleared. `mmcm_reset` is not pulsed.
  3. Counter expiry.
- Press events and `sw_reset_req` are ignored in HOLD_MMCM and WAIT_LOCK.
- Debounce:
  - The counter increments while the synced button is 1 and clears when it is 0.
  - A press event fires once when the count reaches `DEBOUNCE_CYCLES`.
  - The counter saturates there. No further event fires until the button is released.
- Counter width is `$clog2(max(params)+1)`. Counters never wrap.

## Timing
- Reset values, asynchronous on `aresetn`=0: `state`=HOLD_MMCM, `mmcm_reset`=1, `areset`=1, all counters 0, synchronizers 0.
- Outputs are decoded from next-state and registered, so they change on the same edge as `state`.
- Edge k means the k-th rising edge after `aresetn` rises.
  - With locks already high, WAIT_LOCK is entered at edge `MMCM_RST_CYCLES`.
  - STABLE is entered one edge later.
  - `areset` falls at edge `MMCM_RST_CYCLES+1+STABLE_CYCLES`.
- Lock-loss latency: at most 3 edges from the `locked` fall to `areset`/`mmcm_reset` rising (2 sync + 1 state).
- Asserting `aresetn` mid-operation forces outputs high immediately, with no clock required.

## Configuration
- `SIFIVE_RESET_GATE_TIMEOUT_EN`:
  - Defined: WAIT_LOCK counts cycles. Reaching `LOCK_TIMEOUT` returns to HOLD_MMCM, which re-pulses `mmcm_reset`.
  - Undefined: WAIT_LOCK waits indefinitely, and the timeout counter is not instantiated.

## Structure
- Shared package `sifive_reset_pkg`:
  - State encodings HOLD_MMCM/WAIT_LOCK/STABLE/RUN.
  - Default parameter constants.
  - A width helper.
- One sub-module, `sifive_bit_sync`: 2-flop synchronizer with asynchronous active-low clear, instantiated N_LOCK+1 times.

## Test plan
All scenarios use N_LOCK=2, MMCM_RST_CYCLES=8, STABLE_CYCLES=16, DEBOUNCE_CYCLES=4, LOCK_TIMEOUT=64.
- Power-up with `locked`=2'b11 throughout → `mmcm_reset` high through edge 8, `areset` falls at edge 25, `state`=3.
- In RUN, drop `locked[1]` for 1 cycle → `areset`=1 and `mmcm_reset`=1 within 3 edges; `mmcm_reset` held 8 edges; `areset` falls again 17 edges after WAIT_LOCK sees lock.
- In RUN:
  - 3-cycle button glitch → no change.
  - Button held 40 cycles → exactly one re-entry to STABLE, `mmcm_reset` stays 0, `areset` low 16 edges after the press event.
- `locked`=0 forever:
  - Macro defined → `mmcm_reset` pulses 8 cycles every 73 cycles.
  - Macro undefined → `state` stays 1.
- In STABLE at count 10, assert `aresetn` → outputs 1 immediately; after release, the full power-up sequence repeats.
- `sw_reset_req` on the same edge `locked[0]` syncs low → HOLD_MMCM (lock loss wins), `mmcm_reset`=1.

Source files
------------

// File: rtl/sifive_reset_pkg.sv
// sifive_reset_pkg: shared definitions for the VCU118 power-on reset gate.
// Holds the gate FSM state encodings, the default parameter values and a
// small helper that sizes the cycle counters.
package sifive_reset_pkg;

    typedef logic [1:0] gate_state_t;

    localparam gate_state_t HOLD_MMCM = 2'd0;
    localparam gate_state_t WAIT_LOCK = 2'd1;
    localparam gate_state_t STABLE    = 2'd2;
    localparam gate_state_t RUN       = 2'd3;

    localparam int unsigned DEF_N_LOCK          = 4;
    localparam int unsigned DEF_MMCM_RST_CYCLES = 64;
    localparam int unsigned DEF_STABLE_CYCLES   = 4096;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 65536;
    localparam int unsigned DEF_LOCK_TIMEOUT    = 1048576;

    function automatic int unsigned maxOf2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold every value from 0 up to and including maxCount.
    function automatic int unsigned counterWidth(input int unsigned maxCount);
        return $clog2(maxCount + 1);
    endfunction

endpackage

// File: rtl/sifive_bit_sync.sv
// sifive_bit_sync: two-flop synchronizer for one asynchronous level input.
// Both stages clear asynchronously while aresetn is low so the synced value
// starts at 0 after power-on.
module sifive_bit_sync (
    input  logic clock,
    input  logic aresetn,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve metastability
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sifive_reset_gate.sv
// sifive_reset_gate: power-on reset gate for the VCU118 shell.
// Pulses mmcm_reset, waits for every MMCM lock to hold steadily, then releases
// areset to the downstream reset sequencer. A debounced button press or a
// software request restarts the stability window; losing lock restarts the
// whole sequence from the MMCM reset pulse.
// Optional feature: define SIFIVE_RESET_GATE_TIMEOUT_EN to give up waiting for
// lock after LOCK_TIMEOUT cycles and re-pulse the MMCM reset.
module sifive_reset_gate
    import sifive_reset_pkg::*;
#(
    parameter int unsigned N_LOCK          = DEF_N_LOCK,
    parameter int unsigned MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
    parameter int unsigned STABLE_CYCLES   = DEF_STABLE_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT
) (
    input  logic              clock,
    input  logic              aresetn,
    input  logic [N_LOCK-1:0] locked,
    input  logic              button,
    input  logic              sw_reset_req,
    output logic              mmcm_reset,
    output logic              areset,
    output logic [1:0]        state
);

    // One width covers every count this block can reach, so no counter wraps.
    localparam int unsigned CNT_W = counterWidth(maxOf2(maxOf2(MMCM_RST_CYCLES, STABLE_CYCLES),
                                                        maxOf2(DEBOUNCE_CYCLES, LOCK_TIMEOUT)));

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_FIRE     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_SAT      = CNT_W'(DEBOUNCE_CYCLES);

    logic [N_LOCK-1:0] lockedSync;
    logic              allLocked;
    logic              buttonSync;

    logic [CNT_W-1:0]  dbCnt_q;
    logic [CNT_W-1:0]  dbCnt_d;
    logic              pressEvent;

    gate_state_t       state_q;
    gate_state_t       state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              mmcmReset_q;
    logic              areset_q;
    logic              lockTimeout;
    logic              restartReq;

    for (genvar i = 0; i < N_LOCK; i++) begin : g_lockSync
        sifive_bit_sync u_lockSync (
            .clock   (clock),
            .aresetn (aresetn),
            .d_i     (locked[i]),
            .q_o     (lockedSync[i])
        );
    end

    sifive_bit_sync u_buttonSync (
        .clock   (clock),
        .aresetn (aresetn),
        .d_i     (button),
        .q_o     (buttonSync)
    );

    assign allLocked  = &lockedSync;
    assign restartReq = pressEvent | sw_reset_req;

    // Debounce: count consecutive high samples, fire once on reaching the threshold, then hold
    always_comb begin
        dbCnt_d    = '0;
        pressEvent = 1'b0;
        if (buttonSync) begin
            if (dbCnt_q == DB_SAT) begin
                dbCnt_d = DB_SAT;
            end else begin
                dbCnt_d    = dbCnt_q + CNT_ONE;
                pressEvent = (dbCnt_q == DB_FIRE);
            end
        end
    end

    // Debounce counter register
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            dbCnt_q <= '0;
        end else begin
            dbCnt_q <= dbCnt_d;
        end
    end

`ifdef SIFIVE_RESET_GATE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(LOCK_TIMEOUT);

    logic [CNT_W-1:0] toCnt_q;
    logic [CNT_W-1:0] toCnt_d;

    assign lockTimeout = (toCnt_q == TO_LIMIT);

    // Dwell counter for WAIT_LOCK; restarts from zero on every entry into WAIT_LOCK
    always_comb begin
        toCnt_d = '0;
        if ((state_q == WAIT_LOCK) && (state_d == WAIT_LOCK)) begin
            toCnt_d = toCnt_q + CNT_ONE;
        end
    end

    // Lock timeout counter register
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            toCnt_q <= '0;
        end else begin
            toCnt_q <= toCnt_d;
        end
    end
`else
    assign lockTimeout = 1'b0;
`endif

    // Gate FSM: lock loss beats a restart request, which beats the stability countdown
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HOLD_MMCM: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                cnt_d = '0;
                if (allLocked) begin
                    state_d = STABLE;
                end else if (lockTimeout) begin
                    state_d = HOLD_MMCM;
                end
            end
            STABLE: begin
                if (!allLocked) begin
                    state_d = HOLD_MMCM;
                    cnt_d   = '0;
                end else if (restartReq) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!allLocked) begin
                    state_d = HOLD_MMCM;
                end else if (restartReq) begin
                    state_d = STABLE;
                end
            end
            default: begin
                state_d = HOLD_MMCM;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and outputs; outputs are decoded from state_d so they move with state
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= HOLD_MMCM;
            cnt_q       <= '0;
            mmcmReset_q <= 1'b1;
            areset_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mmcmReset_q <= (state_d == HOLD_MMCM);
            areset_q    <= (state_d != RUN);
        end
    end

    assign mmcm_reset = mmcmReset_q;
    assign areset     = areset_q;
    assign state      = state_q;

endmodule

// File: tb/tb_sifive_reset_gate.sv
// tb_sifive_reset_gate: self-checking bench for sifive_reset_gate with
// N_LOCK=2, MMCM_RST_CYCLES=8, STABLE_CYCLES=16, DEBOUNCE_CYCLES=4, LOCK_TIMEOUT=64.
// Expectations for the lock-timeout case follow SIFIVE_RESET_GATE_TIMEOUT_EN.
module tb_sifive_reset_gate;

    localparam int MMCM  = 8;
    localparam int STAB  = 16;
    localparam int DEB   = 4;
    localparam int LOCKT = 64;

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_STAB = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    typedef struct {
        int         cycles;
        logic [1:0] lockedIn;
        logic       buttonIn;
        logic       swIn;
        logic [1:0] expState;
        logic       expMmcm;
        logic       expAreset;
    } vector_t;

    logic       clock = 1'b0;
    logic       aresetn = 1'b0;
    logic [1:0] locked = 2'b00;
    logic       button = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       mmcm_reset;
    logic       areset;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    vector_t vecs[$];

    // Reference model: phase number, edge of phase entry, edge count, button run length
    int         mPhase;
    int         mStart;
    int         mEdge;
    int         mRunLen;
    logic [1:0] lkPrev1;
    logic [1:0] lkPrev2;
    logic       btPrev1;
    logic       btPrev2;

    sifive_reset_gate #(
        .N_LOCK          (2),
        .MMCM_RST_CYCLES (MMCM),
        .STABLE_CYCLES   (STAB),
        .DEBOUNCE_CYCLES (DEB),
        .LOCK_TIMEOUT    (LOCKT)
    ) dut (
        .clock        (clock),
        .aresetn      (aresetn),
        .locked       (locked),
        .button       (button),
        .sw_reset_req (sw_reset_req),
        .mmcm_reset   (mmcm_reset),
        .areset       (areset),
        .state        (state)
    );

    // Free-running reference clock, 10 time units per period
    always #5 clock = ~clock;

    // Hard stop if something keeps the bench from finishing
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired before the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vector_t mkVec(input int cyc, input logic [1:0] lk, input logic bt,
                                      input logic sw, input logic [1:0] st, input logic mm,
                                      input logic ar);
        vector_t v;
        v.cycles    = cyc;
        v.lockedIn  = lk;
        v.buttonIn  = bt;
        v.swIn      = sw;
        v.expState  = st;
        v.expMmcm   = mm;
        v.expAreset = ar;
        return v;
    endfunction

    task automatic modelReset();
        mPhase  = 0;
        mStart  = 0;
        mEdge   = 0;
        mRunLen = 0;
        lkPrev1 = 2'b00;
        lkPrev2 = 2'b00;
        btPrev1 = 1'b0;
        btPrev2 = 1'b0;
    endtask

    task automatic modelEnter(input int phase);
        mPhase = phase;
        mStart = mEdge;
    endtask

    // Inputs reach the FSM two edges after they are sampled; decisions use edge arithmetic
    task automatic modelEdge();
        logic [1:0] lkSeen;
        logic       btSeen;
        logic       lockOk;
        logic       restart;
        mEdge++;
        lkSeen  = lkPrev2;
        btSeen  = btPrev2;
        lkPrev2 = lkPrev1;
        lkPrev1 = locked;
        btPrev2 = btPrev1;
        btPrev1 = button;
        mRunLen = btSeen ? mRunLen + 1 : 0;
        lockOk  = (lkSeen == 2'b11);
        restart = (mRunLen == DEB) || sw_reset_req;
        case (mPhase)
            0: begin
                if (mEdge - mStart == MMCM) modelEnter(1);
            end
            1: begin
                if (lockOk) modelEnter(2);
`ifdef SIFIVE_RESET_GATE_TIMEOUT_EN
                else if (mEdge - mStart == LOCKT + 1) modelEnter(0);
`endif
            end
            default: begin
                if (!lockOk) modelEnter(0);
                else if (restart) modelEnter(2);
                else if ((mPhase == 2) && (mEdge - mStart == STAB)) modelEnter(3);
            end
        endcase
    endtask

    // Advance one clock edge and sample #1 later
    task automatic stepCycle();
        @(posedge clock);
        if (aresetn) modelEdge();
        else modelReset();
        #1;
    endtask

    task automatic applyStimulus(input int cycles, input logic [1:0] lk, input logic bt, input logic sw);
        locked       = lk;
        button       = bt;
        sw_reset_req = sw;
        repeat (cycles) stepCycle();
    endtask

    task automatic doReset(input logic [1:0] lk);
        aresetn = 1'b0;
        applyStimulus(3, lk, 1'b0, 1'b0);
        aresetn = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] expState,
                               input logic expMmcm, input logic expAreset);
        checks++;
        if (state !== expState || mmcm_reset !== expMmcm || areset !== expAreset) begin
            failures++;
            $display("[TB] FAIL %s: got state=%0d mmcm_reset=%0b areset=%0b, expected state=%0d mmcm_reset=%0b areset=%0b",
                     name, state, mmcm_reset, areset, expState, expMmcm, expAreset);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic runVectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            applyStimulus(vecs[i].cycles, vecs[i].lockedIn, vecs[i].buttonIn, vecs[i].swIn);
            checkOutput($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expMmcm, vecs[i].expAreset);
        end
    endtask

    // Main sequence
    initial begin
        int         entries;
        int         rises;
        logic [1:0] prevState;
        logic       prevMmcm;
        logic [1:0] expSt;
        logic       expMm;
        int         dropLeft;
        int         btnLeft;
        logic [1:0] dropMask;
        logic [1:0] lk;
        logic       bt;
        logic       sw;

        // Power-up: edges 7, 8, 9, 24, 25
        vecs.push_back(mkVec(7,  2'b11, 1'b0, 1'b0, S_HOLD, 1'b1, 1'b1));
        vecs.push_back(mkVec(1,  2'b11, 1'b0, 1'b0, S_WAIT, 1'b0, 1'b1));
        vecs.push_back(mkVec(1,  2'b11, 1'b0, 1'b0, S_STAB, 1'b0, 1'b1));
        vecs.push_back(mkVec(15, 2'b11, 1'b0, 1'b0, S_STAB, 1'b0, 1'b1));
        vecs.push_back(mkVec(1,  2'b11, 1'b0, 1'b0, S_RUN,  1'b0, 1'b0));
        vecs.push_back(mkVec(20, 2'b11, 1'b0, 1'b0, S_RUN,  1'b0, 1'b0));
        // Three-cycle button glitch is shorter than the debounce window
        vecs.push_back(mkVec(3,  2'b11, 1'b1, 1'b0, S_RUN,  1'b0, 1'b0));
        vecs.push_back(mkVec(10, 2'b11, 1'b0, 1'b0, S_RUN,  1'b0, 1'b0));
        // One-cycle drop of locked[1]: seen at the third edge, then a full restart
        vecs.push_back(mkVec(1,  2'b01, 1'b0, 1'b0, S_RUN,  1'b0, 1'b0));
        vecs.push_back(mkVec(1,  2'b11, 1'b0, 1'b0, S_RUN,  1'b0, 1'b0));
        vecs.push_back(mkVec(1,  2'b11, 1'b0, 1'b0, S_HOLD, 1'b1, 1'b1));
        vecs.push_back(mkVec(7,  2'b11, 1'b0, 1'b0, S_HOLD, 1'b1, 1'b1));
        vecs.push_back(mkVec(1,  2'b11, 1'b0, 1'b0, S_WAIT, 1'b0, 1'b1));
        vecs.push_back(mkVec(1,  2'b11, 1'b0, 1'b0, S_STAB, 1'b0, 1'b1));
        vecs.push_back(mkVec(15, 2'b11, 1'b0, 1'b0, S_STAB, 1'b0, 1'b1));
        vecs.push_back(mkVec(1,  2'b11, 1'b0, 1'b0, S_RUN,  1'b0, 1'b0));

        $display("[TB] reset state");
        doReset(2'b11);
        checkOutput("reset_state", S_HOLD, 1'b1, 1'b1);

        $display("[TB] power-up, glitch and lock-drop vectors");
        runVectors(0, vecs.size() - 1);

        $display("[TB] button held 40 cycles in RUN");
        entries   = 0;
        prevState = state;
        for (int k = 1; k <= 50; k++) begin
            applyStimulus(1, 2'b11, (k <= 40), 1'b0);
            expSt = (k < 6) ? S_RUN : ((k < 6 + STAB) ? S_STAB : S_RUN);
            checkOutput($sformatf("button_hold_k%0d", k), expSt, 1'b0, (expSt != S_RUN));
            if (prevState == S_RUN && state == S_STAB) entries++;
            prevState = state;
        end
        checkValue("button_hold_reentries", entries, 1);

        $display("[TB] software reset request in RUN");
        applyStimulus(1, 2'b11, 1'b0, 1'b1);
        checkOutput("sw_req_enter", S_STAB, 1'b0, 1'b1);
        applyStimulus(15, 2'b11, 1'b0, 1'b0);
        checkOutput("sw_req_hold", S_STAB, 1'b0, 1'b1);
        applyStimulus(1, 2'b11, 1'b0, 1'b0);
        checkOutput("sw_req_run", S_RUN, 1'b0, 1'b0);

        $display("[TB] software request coincides with synced lock loss");
        applyStimulus(1, 2'b10, 1'b0, 1'b0);
        checkOutput("prio_edge1", S_RUN, 1'b0, 1'b0);
        applyStimulus(1, 2'b11, 1'b0, 1'b0);
        applyStimulus(1, 2'b11, 1'b0, 1'b1);
        checkOutput("prio_lock_wins", S_HOLD, 1'b1, 1'b1);
        applyStimulus(8, 2'b11, 1'b0, 1'b0);
        checkOutput("prio_wait", S_WAIT, 1'b0, 1'b1);

        $display("[TB] aresetn asserted in STABLE at count 10");
        doReset(2'b11);
        applyStimulus(MMCM + 1 + 10, 2'b11, 1'b0, 1'b0);
        checkOutput("stable_count10", S_STAB, 1'b0, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("async_reset", S_HOLD, 1'b1, 1'b1);
        applyStimulus(2, 2'b11, 1'b0, 1'b0);
        aresetn = 1'b1;
        runVectors(0, 4);

        $display("[TB] locks never assert");
        doReset(2'b00);
        rises    = 0;
        prevMmcm = mmcm_reset;
        for (int e = 1; e <= 160; e++) begin
            applyStimulus(1, 2'b00, 1'b0, 1'b0);
`ifdef SIFIVE_RESET_GATE_TIMEOUT_EN
            expMm = ((e % (MMCM + LOCKT + 1)) < MMCM);
`else
            expMm = (e < MMCM);
`endif
            checkOutput($sformatf("no_lock_e%0d", e), expMm ? S_HOLD : S_WAIT, expMm, 1'b1);
            if (!prevMmcm && mmcm_reset) rises++;
            prevMmcm = mmcm_reset;
        end
`ifdef SIFIVE_RESET_GATE_TIMEOUT_EN
        checkValue("no_lock_repulses", rises, 2);
`else
        checkValue("no_lock_repulses", rises, 0);
`endif

        $display("[TB] randomized stimulus against reference model");
        doReset(2'b11);
        dropLeft = 0;
        btnLeft  = 0;
        dropMask = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if (dropLeft > 0) begin
                dropLeft--;
            end else if ($urandom_range(0, 299) == 0) begin
                dropLeft = int'($urandom_range(1, 4));
                dropMask = 2'($urandom_range(1, 3));
            end
            lk = (dropLeft > 0) ? ~dropMask : 2'b11;
            if (btnLeft > 0) begin
                btnLeft--;
            end else if ($urandom_range(0, 29) == 0) begin
                btnLeft = int'($urandom_range(1, 8));
            end
            bt = (btnLeft > 0);
            sw = ($urandom_range(0, 149) == 0);
            applyStimulus(1, lk, bt, sw);
            checkOutput($sformatf("random_cycle%0d", i), 2'(mPhase), (mPhase == 0), (mPhase != 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
